vcve2_vlsu_sequencer: RTL and testbench

//  Sequences one vector load/store into per-element 32-bit LSU transactions.

---
 rtl/vcve2_vec_pkg.sv | 19 +
 rtl/vcve2_vlsu_sequencer_if.sv | 20 ++
 rtl/vcve2_lsu_interface.sv | 70 +++++++
 rtl/vcve2_vlsu_sequencer.sv | 127 ++++++++++++
 tb/tb_vcve2_vlsu_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vcve2_vec_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vcve2_vec_pkg
// Brief   : Shared types and constants for the vector LSU sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package vcve2_vec_pkg;

  typedef enum logic [1:0] {
    VLSU_IDLE  = 2'd0,
    VLSU_ISSUE = 2'd1,
    VLSU_WAIT  = 2'd2,
    VLSU_DONE  = 2'd3
  } vlsu_state_e;

  localparam logic [31:0] VLSU_UNIT_STRIDE = 32'd4;

endpackage
`default_nettype wire

// File: rtl/vcve2_vlsu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : vcve2_vlsu_sequencer_if
// Brief   : Request/grant/response LSU bus, used for the scalar and core sides.
// Revision: 1.0 - initial release
// ============================================================================
interface vcve2_vlsu_sequencer_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface
`default_nettype wire

// File: rtl/vcve2_lsu_interface.sv
`default_nettype none
// ============================================================================
// Module  : vcve2_lsu_interface
// Brief   : Element address counter and vector/scalar LSU port mux.
// Revision: 1.0 - initial release
// ============================================================================
module vcve2_lsu_interface
  import vcve2_vec_pkg::*;
(
  input  wire logic          i_clk,
  input  wire logic          i_rst_n,
  input  wire logic          i_load_start,
  input  wire logic          i_advance,
  input  wire logic [31:0]   i_base_addr,
  input  wire logic [31:0]   i_stride,
  input  wire logic          i_unit_stride,
  input  wire logic          i_vec_op,
  input  wire logic          i_vec_req,
  input  wire logic          i_vec_we,
  input  wire logic [31:0]   i_vec_wdata,
  input  wire logic          i_scalar_block,
  vcve2_vlsu_sequencer_if.slave  scalar,
  vcve2_vlsu_sequencer_if.master lsu
);

  logic [31:0] r_addr;
  logic [31:0] r_step;

  // Step is latched with the base so a mid-op stride change cannot skew addresses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr <= '0;
      r_step <= '0;
    end else if (i_load_start) begin
      r_addr <= i_base_addr;
      r_step <= i_unit_stride ? VLSU_UNIT_STRIDE : i_stride;
    end else if (i_advance) begin
      r_addr <= r_addr + r_step;
    end
  end

  always_comb begin
    lsu.req       = 1'b0;
    lsu.we        = 1'b0;
    lsu.addr      = '0;
    lsu.wdata     = '0;
    scalar.gnt    = 1'b0;
    scalar.rvalid = 1'b0;
    scalar.rdata  = lsu.rdata;
    scalar.err    = 1'b0;
    if (i_vec_op) begin
      lsu.req   = i_vec_req;
      lsu.we    = i_vec_req & i_vec_we;
      lsu.addr  = i_vec_req ? r_addr : '0;
      lsu.wdata = (i_vec_req & i_vec_we) ? i_vec_wdata : '0;
    end else begin
      // A pending vector start blocks new scalar grants but still lets the
      // outstanding scalar response through.
      lsu.req       = scalar.req & ~i_scalar_block;
      lsu.we        = scalar.we;
      lsu.addr      = scalar.addr;
      lsu.wdata     = scalar.wdata;
      scalar.gnt    = lsu.gnt & ~i_scalar_block;
      scalar.rvalid = lsu.rvalid;
      scalar.err    = lsu.err & lsu.rvalid;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vcve2_vlsu_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : vcve2_vlsu_sequencer
// Brief   : Splits one vector load/store into 32-bit LSU element transactions.
// Revision: 1.0 - initial release
// ============================================================================
module vcve2_vlsu_sequencer
  import vcve2_vec_pkg::*;
#(
  parameter int MAX_VL = 32,
  parameter int ELEM_W = 32,
  localparam int CW = $clog2(MAX_VL + 1)
) (
  input  wire logic              clk_i,
  input  wire logic              rst_ni,
  input  wire logic              vec_start_i,
  input  wire logic              vec_store_i,
  input  wire logic [31:0]       base_addr_i,
  input  wire logic [31:0]       stride_i,
  input  wire logic              unit_stride_i,
  input  wire logic [CW-1:0]     vl_i,
  vcve2_vlsu_sequencer_if.slave  scalar,
  vcve2_vlsu_sequencer_if.master lsu,
  output logic [CW-1:0]          vrf_ridx_o,
  input  wire logic [ELEM_W-1:0] vrf_rdata_i,
  output logic                   vrf_we_o,
  output logic [CW-1:0]          vrf_widx_o,
  output logic [ELEM_W-1:0]      vrf_wdata_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  vlsu_state_e   r_state;
  logic [CW-1:0] r_idx;
  logic [CW-1:0] r_vl;
  logic          r_store;
  logic          r_err;
  logic          r_pending;
  logic          r_scalar_out;

  logic w_idle;
  logic w_scalar_fire;
  logic w_scalar_busy;
  logic w_elem_ok;

  assign w_idle        = (r_state == VLSU_IDLE);
  assign w_scalar_fire = w_idle & scalar.req & ~r_pending & lsu.gnt;
  assign w_scalar_busy = w_scalar_fire | (r_scalar_out & ~lsu.rvalid);
  assign w_elem_ok     = (r_state == VLSU_WAIT) & lsu.rvalid & ~lsu.err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= VLSU_IDLE;
      r_idx        <= '0;
      r_vl         <= '0;
      r_store      <= 1'b0;
      r_err        <= 1'b0;
      r_pending    <= 1'b0;
      r_scalar_out <= 1'b0;
    end else begin
      case (r_state)
        VLSU_IDLE: begin
          r_scalar_out <= w_scalar_busy;
          if (r_pending) begin
            if (lsu.rvalid) begin
              r_pending <= 1'b0;
              r_state   <= (r_vl == '0) ? VLSU_DONE : VLSU_ISSUE;
            end
          end else if (vec_start_i) begin
            r_store <= vec_store_i;
            r_vl    <= vl_i;
            r_idx   <= '0;
            r_err   <= 1'b0;
            if (w_scalar_busy) begin
              r_pending <= 1'b1;
            end else begin
              r_state <= (vl_i == '0) ? VLSU_DONE : VLSU_ISSUE;
            end
          end
        end
        VLSU_ISSUE: begin
          if (lsu.gnt) r_state <= VLSU_WAIT;
        end
        VLSU_WAIT: begin
          if (lsu.rvalid) begin
            if (lsu.err) begin
              r_err   <= 1'b1;
              r_state <= VLSU_DONE;
            end else begin
              r_idx   <= r_idx + CW'(1);
              r_state <= (r_idx == r_vl - CW'(1)) ? VLSU_DONE : VLSU_ISSUE;
            end
          end
        end
        default: r_state <= VLSU_IDLE;
      endcase
    end
  end

  assign busy_o      = ~w_idle;
  assign done_o      = (r_state == VLSU_DONE);
  assign err_o       = (r_state == VLSU_DONE) & r_err;
  assign vrf_ridx_o  = (r_state == VLSU_ISSUE) ? r_idx : '0;
  assign vrf_we_o    = w_elem_ok & ~r_store;
  assign vrf_widx_o  = vrf_we_o ? r_idx : '0;
  assign vrf_wdata_o = lsu.rdata;

  vcve2_lsu_interface u_lsu_if (
    .i_clk          (clk_i),
    .i_rst_n        (rst_ni),
    .i_load_start   (w_idle & ~r_pending & vec_start_i),
    .i_advance      (w_elem_ok),
    .i_base_addr    (base_addr_i),
    .i_stride       (stride_i),
    .i_unit_stride  (unit_stride_i),
    .i_vec_op       (~w_idle),
    .i_vec_req      (r_state == VLSU_ISSUE),
    .i_vec_we       (r_store),
    .i_vec_wdata    (vrf_rdata_i),
    .i_scalar_block (r_pending),
    .scalar         (scalar),
    .lsu            (lsu)
  );

endmodule
`default_nettype wire

// File: tb/tb_vcve2_vlsu_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_vcve2_vlsu_sequencer
// Brief   : Directed bench for the vector LSU sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vcve2_vlsu_sequencer;

  localparam int CW = 6;

  logic          clk;
  logic          rst_n;
  logic          vec_start;
  logic          vec_store;
  logic [31:0]   base_addr;
  logic [31:0]   stride;
  logic          unit_stride;
  logic [CW-1:0] vl;
  logic [CW-1:0] vrf_ridx;
  logic [31:0]   vrf_rdata;
  logic          vrf_we;
  logic [CW-1:0] vrf_widx;
  logic [31:0]   vrf_wdata;
  logic          busy;
  logic          done;
  logic          err;

  logic [31:0] vrf_mem [0:31];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          t0;

  vcve2_vlsu_sequencer_if scalar_bus ();
  vcve2_vlsu_sequencer_if lsu_bus ();

  vcve2_vlsu_sequencer dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .vec_start_i   (vec_start),
    .vec_store_i   (vec_store),
    .base_addr_i   (base_addr),
    .stride_i      (stride),
    .unit_stride_i (unit_stride),
    .vl_i          (vl),
    .scalar        (scalar_bus),
    .lsu           (lsu_bus),
    .vrf_ridx_o    (vrf_ridx),
    .vrf_rdata_i   (vrf_rdata),
    .vrf_we_o      (vrf_we),
    .vrf_widx_o    (vrf_widx),
    .vrf_wdata_o   (vrf_wdata),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err)
  );

  assign vrf_rdata = vrf_mem[vrf_ridx[4:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) vrf_mem[i] = 32'hC0DE_0000 + i;
    rst_n = 1'b0; vec_start = 1'b0; vec_store = 1'b0; base_addr = '0;
    stride = '0; unit_stride = 1'b0; vl = '0;
    scalar_bus.req = 1'b0; scalar_bus.we = 1'b0; scalar_bus.addr = '0; scalar_bus.wdata = '0;
    lsu_bus.gnt = 1'b0; lsu_bus.rvalid = 1'b0; lsu_bus.rdata = '0; lsu_bus.err = 1'b0;

    // Reset state
    tick(); tick(); #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_req",  32'(lsu_bus.req), 0);
    chk("rst_vrfwe", 32'(vrf_we), 0);
    rst_n = 1'b1;
    tick();

    // 1: unit-stride load, zero-wait
    vec_start = 1'b1; vec_store = 1'b0; base_addr = 32'h1000; unit_stride = 1'b1;
    stride = 32'h55; vl = 6'd4; t0 = cyc; #1;
    chk("t1_idle_busy", 32'(busy), 0);
    tick(); vec_start = 1'b0;
    for (int e = 0; e < 4; e++) begin
      lsu_bus.gnt = 1'b1; lsu_bus.rvalid = 1'b0; #1;
      chk("t1_req",  32'(lsu_bus.req), 1);
      chk("t1_addr", lsu_bus.addr, 32'h1000 + 4 * e);
      chk("t1_we",   32'(lsu_bus.we), 0);
      tick();
      lsu_bus.gnt = 1'b0; lsu_bus.rvalid = 1'b1; lsu_bus.rdata = 32'hA0 + e; #1;
      chk("t1_wait_req", 32'(lsu_bus.req), 0);
      chk("t1_vrfwe",    32'(vrf_we), 1);
      chk("t1_widx",     32'(vrf_widx), e);
      chk("t1_wdata",    vrf_wdata, 32'hA0 + e);
      tick();
    end
    lsu_bus.rvalid = 1'b0; #1;
    chk("t1_done",    32'(done), 1);
    chk("t1_err",     32'(err), 0);
    chk("t1_latency", 32'(cyc - t0), 9);
    tick(); #1;
    chk("t1_idle", 32'(busy), 0);
    chk("t1_done_pulse", 32'(done), 0);

    // 2: strided store
    vec_start = 1'b1; vec_store = 1'b1; base_addr = 32'h2000; unit_stride = 1'b0;
    stride = 32'h10; vl = 6'd3;
    tick(); vec_start = 1'b0;
    for (int e = 0; e < 3; e++) begin
      lsu_bus.gnt = 1'b1; #1;
      chk("t2_we",    32'(lsu_bus.we), 1);
      chk("t2_addr",  lsu_bus.addr, 32'h2000 + 32'h10 * e);
      chk("t2_wdata", lsu_bus.wdata, 32'hC0DE_0000 + e);
      tick();
      lsu_bus.gnt = 1'b0; lsu_bus.rvalid = 1'b1; #1;
      chk("t2_no_vrfwe", 32'(vrf_we), 0);
      tick();
      lsu_bus.rvalid = 1'b0;
    end
    #1;
    chk("t2_done", 32'(done), 1);
    chk("t2_err",  32'(err), 0);
    tick();

    // 3: vl == 0
    vec_start = 1'b1; vec_store = 1'b0; vl = 6'd0; #1;
    chk("t3_req0", 32'(lsu_bus.req), 0);
    tick(); vec_start = 1'b0; #1;
    chk("t3_done", 32'(done), 1);
    chk("t3_req1", 32'(lsu_bus.req), 0);
    chk("t3_err",  32'(err), 0);
    tick(); #1;
    chk("t3_idle", 32'(busy), 0);

    // 4: bus error on element 1
    vec_start = 1'b1; vec_store = 1'b0; base_addr = 32'h3000; unit_stride = 1'b1; vl = 6'd4;
    tick(); vec_start = 1'b0;
    lsu_bus.gnt = 1'b1; tick();
    lsu_bus.gnt = 1'b0; lsu_bus.rvalid = 1'b1; lsu_bus.rdata = 32'h11; #1;
    chk("t4_vrfwe0", 32'(vrf_we), 1);
    chk("t4_widx0",  32'(vrf_widx), 0);
    tick();
    lsu_bus.rvalid = 1'b0; lsu_bus.gnt = 1'b1; #1;
    chk("t4_addr1", lsu_bus.addr, 32'h3004);
    tick();
    lsu_bus.gnt = 1'b0; lsu_bus.rvalid = 1'b1; lsu_bus.err = 1'b1; #1;
    chk("t4_no_vrfwe1", 32'(vrf_we), 0);
    tick();
    lsu_bus.rvalid = 1'b0; lsu_bus.err = 1'b0; #1;
    chk("t4_done", 32'(done), 1);
    chk("t4_err",  32'(err), 1);
    chk("t4_req_done", 32'(lsu_bus.req), 0);
    tick(); #1;
    chk("t4_idle", 32'(busy), 0);
    chk("t4_no_req3", 32'(lsu_bus.req), 0);
    chk("t4_err_pulse", 32'(err), 0);

    // 5: scalar contention
    scalar_bus.req = 1'b1; scalar_bus.addr = 32'h5000; lsu_bus.gnt = 1'b1; #1;
    chk("t5_pass_req",  32'(lsu_bus.req), 1);
    chk("t5_pass_addr", lsu_bus.addr, 32'h5000);
    chk("t5_sgnt",      32'(scalar_bus.gnt), 1);
    tick();
    scalar_bus.req = 1'b0; lsu_bus.gnt = 1'b0;
    vec_start = 1'b1; vec_store = 1'b0; base_addr = 32'h6000; unit_stride = 1'b1; vl = 6'd2; #1;
    chk("t5_pend_req", 32'(lsu_bus.req), 0);
    tick(); vec_start = 1'b0; #1;
    chk("t5_pend_busy", 32'(busy), 0);
    chk("t5_pend_req2", 32'(lsu_bus.req), 0);
    lsu_bus.rvalid = 1'b1; #1;
    chk("t5_srvalid", 32'(scalar_bus.rvalid), 1);
    tick();
    lsu_bus.rvalid = 1'b0;
    scalar_bus.req = 1'b1; scalar_bus.addr = 32'h7000; lsu_bus.gnt = 1'b1; #1;
    chk("t5_vec_busy", 32'(busy), 1);
    chk("t5_vec_addr", lsu_bus.addr, 32'h6000);
    chk("t5_sgnt_busy", 32'(scalar_bus.gnt), 0);
    tick();
    lsu_bus.gnt = 1'b0; lsu_bus.rvalid = 1'b1; #1;
    chk("t5_srvalid_busy", 32'(scalar_bus.rvalid), 0);
    tick();
    lsu_bus.rvalid = 1'b0; lsu_bus.gnt = 1'b1; #1;
    chk("t5_vec_addr1", lsu_bus.addr, 32'h6004);
    tick();
    lsu_bus.gnt = 1'b0; lsu_bus.rvalid = 1'b1; tick();
    lsu_bus.rvalid = 1'b0; #1;
    chk("t5_done", 32'(done), 1);
    chk("t5_req_in_done", 32'(lsu_bus.req), 0);
    tick();
    lsu_bus.gnt = 1'b1; #1;
    chk("t5_scalar_req", 32'(lsu_bus.req), 1);
    chk("t5_scalar_addr", lsu_bus.addr, 32'h7000);
    chk("t5_sgnt_idle", 32'(scalar_bus.gnt), 1);
    tick();
    scalar_bus.req = 1'b0; scalar_bus.addr = '0; lsu_bus.gnt = 1'b0; lsu_bus.rvalid = 1'b1;
    tick();
    lsu_bus.rvalid = 1'b0;

    // 6: grant backpressure, then reset mid-op
    vec_start = 1'b1; vec_store = 1'b1; base_addr = 32'h8000; unit_stride = 1'b0;
    stride = 32'h8; vl = 6'd2;
    tick(); vec_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t6_hold_req",   32'(lsu_bus.req), 1);
      chk("t6_hold_addr",  lsu_bus.addr, 32'h8000);
      chk("t6_hold_we",    32'(lsu_bus.we), 1);
      chk("t6_hold_wdata", lsu_bus.wdata, 32'hC0DE_0000);
      tick();
    end
    lsu_bus.gnt = 1'b1; tick();
    lsu_bus.gnt = 1'b0; #1;
    chk("t6_wait_busy", 32'(busy), 1);
    rst_n = 1'b0; #1;
    chk("t6_rst_busy",  32'(busy), 0);
    chk("t6_rst_req",   32'(lsu_bus.req), 0);
    chk("t6_rst_addr",  lsu_bus.addr, 0);
    chk("t6_rst_wdata", lsu_bus.wdata, 0);
    chk("t6_rst_done",  32'(done), 0);
    chk("t6_rst_vrfwe", 32'(vrf_we), 0);
    tick();
    rst_n = 1'b1;
    tick(); #1;
    chk("t6_post_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
